// File: rtl/block_spawner_if.sv
// block_spawner_if: handshake between the game top level / block mover and block_spawner.
interface block_spawner_if;
  logic        start;
  logic        collision;
  logic        end_level;
  logic [9:0]  Block_X_Center;
  logic        block_ready;
  logic        respawn;
  logic [3:0]  level;
  logic [2:0]  lives;
  logic        game_over;
  logic [15:0] score;
  modport master (
    output start, collision, end_level,
    input  Block_X_Center, block_ready, respawn, level, lives, game_over, score
  );
  modport slave (
    input  start, collision, end_level,
    output Block_X_Center, block_ready, respawn, level, lives, game_over, score
  );
endinterface

// File: rtl/block_spawner.sv
// block_spawner: picks block columns, releases blocks and sequences lives/levels/difficulty.
// Define SPAWNER_SCORE_EN to keep a dodged-block score; otherwise score is tied to zero.
module block_spawner #(
  parameter logic [9:0] X_MIN            = 10'd40,
  parameter logic [9:0] X_MAX            = 10'd600,
  parameter logic [9:0] X_RESET          = 10'd320,
  parameter logic [9:0] LFSR_SEED        = 10'h2A5,
  parameter int         BLOCKS_PER_LEVEL = 8,
  parameter int         GAP_INIT         = 60,
  parameter int         GAP_DEC          = 6,
  parameter int         GAP_MIN          = 12,
  parameter int         LIVES            = 3
) (
  input logic            frame_clk,
  input logic            Reset,
  block_spawner_if.slave b
);
  typedef enum logic [2:0] {IDLE, ARM, RELEASE, LEVEL_UP, GAME_OVER} state_t;
  state_t     state, nxt;
  logic [7:0] gap, gap_cnt, blocks_left, new_gap, arm_gap;
  logic [9:0] lfsr, src, hi, col;
  logic       coll_q, coll_ev, arm_in;
  always_comb begin
    coll_ev = b.collision & ~coll_q;
    nxt = state == IDLE    ? (b.start ? ARM : IDLE)
        : state == ARM     ? (gap_cnt == 8'd0 ? RELEASE : ARM)
        : state == RELEASE ? (coll_ev ? (b.lives == 3'd1 ? GAME_OVER : ARM)
                             : b.end_level ? (blocks_left == 8'd1 ? LEVEL_UP : ARM) : RELEASE)
        : state == LEVEL_UP ? ARM
        : (b.start ? ARM : GAME_OVER);
    arm_in = nxt == ARM && state != ARM;
    // a restart draws its first column from the reseeded LFSR
    src = state == GAME_OVER ? LFSR_SEED : lfsr;
    hi  = src > X_MAX ? src - (X_MAX - X_MIN + 10'd1) : src;
    col = hi < X_MIN ? hi + X_MIN : hi;
    new_gap = gap >= 8'(GAP_MIN + GAP_DEC) ? gap - 8'(GAP_DEC) : 8'(GAP_MIN);
    arm_gap = state == LEVEL_UP ? new_gap : state == GAME_OVER ? 8'(GAP_INIT) : gap;
  end
  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) begin
      state            <= IDLE;
      b.Block_X_Center <= X_RESET;
      b.block_ready    <= 1'b0;
      b.respawn        <= 1'b0;
      b.level          <= 4'd1;
      b.lives          <= 3'(LIVES);
      b.game_over      <= 1'b0;
      gap              <= 8'(GAP_INIT);
      gap_cnt          <= 8'd0;
      blocks_left      <= 8'(BLOCKS_PER_LEVEL);
      lfsr             <= LFSR_SEED;
      coll_q           <= 1'b0;
    end else begin
      state         <= nxt;
      coll_q        <= b.collision;
      b.block_ready <= nxt == RELEASE;
      b.game_over   <= nxt == GAME_OVER;
      b.respawn     <= arm_in;
      if (arm_in) begin
        b.Block_X_Center <= col;
        lfsr             <= {src[8:0], src[9] ^ src[6]};
        gap_cnt          <= arm_gap - 8'd1;
      end else if (state == ARM && gap_cnt != 8'd0)
        gap_cnt <= gap_cnt - 8'd1;
      if (state == RELEASE && coll_ev)
        b.lives <= b.lives - 3'd1;
      if (state == RELEASE && !coll_ev && b.end_level && blocks_left != 8'd1)
        blocks_left <= blocks_left - 8'd1;
      if (state == LEVEL_UP) begin
        b.level     <= b.level == 4'd15 ? b.level : b.level + 4'd1;
        blocks_left <= 8'(BLOCKS_PER_LEVEL);
        gap         <= new_gap;
      end
      if (state == GAME_OVER && b.start) begin
        b.level     <= 4'd1;
        b.lives     <= 3'(LIVES);
        gap         <= 8'(GAP_INIT);
        blocks_left <= 8'(BLOCKS_PER_LEVEL);
      end
    end
`ifdef SPAWNER_SCORE_EN
  logic [15:0] score_q;
  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset)
      score_q <= 16'd0;
    else if (state == GAME_OVER && b.start)
      score_q <= 16'd0;
    else if (state == RELEASE && !coll_ev && b.end_level && score_q != 16'hFFFF)
      score_q <= score_q + 16'd1;
  assign b.score = score_q;
`else
  assign b.score = 16'd0;
`endif
endmodule
